// File: rtl/rx_parity_engine.sv
// -----------------------------------------------------------------------------
// rx_parity_engine
//
// Receive-side parity engine for the UART Rx path. It assembles DATA_WIDTH
// serial bits LSB-first from the bit-sample strobe and accumulates parity as
// the bits arrive. It then checks the trailing parity bit against the parity
// mode that was latched at frame start. The assembled word is reported with a
// one-cycle valid pulse, a coincident error pulse and a sticky error flag.
//
// Optional feature macro: RX_PARITY_ERR_COUNTER_EN
//   When defined, adds the err_count port and a saturating mismatch counter.
//   The counter is cleared by clear_err and by reset.
//
// Parameters
//   DATA_WIDTH        data bits per frame, legal 5..9
//   CNT_WIDTH         width of the parity error counter
//
// Ports
//   clk               single clock, all logic on the rising edge
//   reset             synchronous, active-low reset
//   parity_mode[2:0]  000 none, 001 even, 010 odd, 011 mark, 100 space,
//                     other codes are treated as none
//   frame_start       one-cycle pulse at start-bit detection
//   bit_valid         one-cycle strobe, serial_in_synced is a valid sample
//   serial_in_synced  synchronised Rx line
//   frame_abort       drop the current frame (framing/break seen upstream)
//   clear_err         clears parity_err_sticky (and err_count)
//   data_out          last assembled word, LSB = first received bit
//   data_valid        one-cycle pulse, data_out/rx_error are valid
//   rx_error          one-cycle pulse with data_valid on a parity mismatch
//   parity_err_sticky set on any mismatch, held until clear_err
//   busy              high while a frame is being received (DATA/PARITY)
//   err_count         saturating mismatch count (macro builds only)
// -----------------------------------------------------------------------------
module rx_parity_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            parity_mode,
    input  logic                  frame_start,
    input  logic                  bit_valid,
    input  logic                  serial_in_synced,
    input  logic                  frame_abort,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  rx_error,
    output logic                  parity_err_sticky,
    output logic                  busy
`ifdef RX_PARITY_ERR_COUNTER_EN
    ,
    output logic [CNT_WIDTH-1:0]  err_count
`endif
);

    // Bit counter only has to reach DATA_WIDTH-1 before the frame moves on.
    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        MODE_NONE  = 3'b000,
        MODE_EVEN  = 3'b001,
        MODE_ODD   = 3'b010,
        MODE_MARK  = 3'b011,
        MODE_SPACE = 3'b100
    } mode_e;

    // Unused encodings collapse to NONE at latch time, so the rest of the
    // datapath only ever sees the five legal modes.
    function automatic mode_e decode_mode(input logic [2:0] m);
        case (m)
            3'b001:  return MODE_EVEN;
            3'b010:  return MODE_ODD;
            3'b011:  return MODE_MARK;
            3'b100:  return MODE_SPACE;
            default: return MODE_NONE;
        endcase
    endfunction

    // CNT_WIDTH is only consumed by the optional counter; this keeps the
    // legality rule for both parameters visible in every build.
    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || CNT_WIDTH < 1) begin : g_illegal_params
        end
    endgenerate

    state_e                  state_q, state_d;
    mode_e                   mode_q, mode_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                    par_q, par_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    rxerr_q, rxerr_d;
    logic                    sticky_q, sticky_d;
    logic                    exp_par;
    logic                    mismatch;

    // Parity bit the transmitter should have sent for the latched mode.
    always_comb begin
        case (mode_q)
            MODE_EVEN: exp_par = par_q;
            MODE_ODD:  exp_par = ~par_q;
            MODE_MARK: exp_par = 1'b1;
            default:   exp_par = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        rxerr_d   = 1'b0;
        mismatch  = 1'b0;
        // clear_err is applied first so that a mismatch in the same cycle
        // still leaves the flag set.
        sticky_d  = clear_err ? 1'b0 : sticky_q;

        // frame_start outranks abort and any coincident sample, in every state.
        if (frame_start) begin
            state_d   = ST_DATA;
            mode_d    = decode_mode(parity_mode);
            shift_d   = '0;
            bit_cnt_d = '0;
            par_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Strobes and aborts outside a frame are ignored.
                end

                ST_DATA: begin
                    if (frame_abort) begin
                        state_d = ST_IDLE;
                    end else if (bit_valid) begin
                        // Shift right, new bit enters at the MSB so the first
                        // received bit ends up at bit 0.
                        shift_d   = {serial_in_synced, shift_q[DATA_WIDTH-1:1]};
                        par_d     = par_q ^ serial_in_synced;
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            if (mode_q == MODE_NONE) begin
                                state_d = ST_IDLE;
                                data_d  = shift_d;
                                valid_d = 1'b1;
                            end else begin
                                state_d = ST_PARITY;
                            end
                        end
                    end
                end

                ST_PARITY: begin
                    if (frame_abort) begin
                        state_d = ST_IDLE;
                    end else if (bit_valid) begin
                        mismatch = serial_in_synced ^ exp_par;
                        data_d   = shift_q;
                        valid_d  = 1'b1;
                        rxerr_d  = mismatch;
                        if (mismatch) begin
                            sticky_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_NONE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            rxerr_q   <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            rxerr_q   <= rxerr_d;
            sticky_q  <= sticky_d;
        end
    end

`ifdef RX_PARITY_ERR_COUNTER_EN
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d, err_cnt_base;

    // Clear first, then count, so clear_err plus a mismatch yields 1.
    always_comb begin
        err_cnt_base = clear_err ? '0 : err_cnt_q;
        err_cnt_d    = err_cnt_base;
        if (mismatch && (err_cnt_base != {CNT_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_base + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign data_out          = data_q;
    assign data_valid        = valid_q;
    assign rx_error          = rxerr_q;
    assign parity_err_sticky = sticky_q;
    assign busy              = (state_q != ST_IDLE);

endmodule
